// File: rtl/ofm_drain_pkg.sv
// Shared types and default geometry for the output-feature-map drain.
package ofm_drain_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAP_SIZE   = 32;
  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_OUT_WIDTH  = 64;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int MAP_BITS = DEF_DATA_WIDTH * (DEF_MAP_SIZE / 2) * (DEF_MAP_SIZE / 2);
  localparam int BEATS    = MAP_BITS / DEF_OUT_WIDTH;
  localparam int BEAT_W   = clog2_min1(BEATS);
  localparam int LEVEL_W  = $clog2(DEF_FIFO_DEPTH) + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/ofm_fifo.sv
// Synchronous FIFO of {addr,map} entries; push while full is accepted when a pop
// happens on the same edge.
module ofm_fifo
  import ofm_drain_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = clog2_min1(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push, do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  // NOTE: the storage array has no reset; only entries counted by 'count' are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ofm_drain.sv
// Buffers whole pooled maps and serialises them LSB-first into valid/ready beats.
// Optional write-pair ordering check is enabled by defining OFM_PAIR_CHECK_EN.
module ofm_drain
  import ofm_drain_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int MAP_SIZE   = DEF_MAP_SIZE,
  parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter  int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int MAP_W      = DATA_WIDTH * (MAP_SIZE / 2) * (MAP_SIZE / 2),
  localparam int N_BEATS    = MAP_W / OUT_WIDTH,
  localparam int BEAT_IW    = clog2_min1(N_BEATS),
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ofm_wr,
  input  logic [ADDR_WIDTH-1:0] ofm_addr,
  input  logic [MAP_W-1:0]      ofm_writedata,
  input  logic                  clear,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [BEAT_IW-1:0]    m_beat,
  output logic                  m_last,
  output logic [LVL_W-1:0]      level,
  output logic                  overflow
`ifdef OFM_PAIR_CHECK_EN
  ,
  output logic                  pair_err
`endif
);

  localparam int ENTRY_W = ADDR_WIDTH + MAP_W;

  state_t             state, state_nxt;
  logic               fifo_full, fifo_empty;
  logic               push, pop, shift, hs, last_beat, drop;
  logic [ENTRY_W-1:0] head;
  logic [MAP_W-1:0]   shifter;
  logic [BEAT_IW-1:0] beat;

  assign hs        = (state == STREAM) && m_ready;
  assign last_beat = (beat == BEAT_IW'(N_BEATS - 1));
  // Full FIFO still accepts a write when the head leaves on the same edge.
  assign push      = ofm_wr && !clear && (!fifo_full || pop);
  assign drop      = ofm_wr && !clear && fifo_full && !pop;

  ofm_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (push),
    .din   ({ofm_addr, ofm_writedata}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaults come first so every path assigns each output and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (!fifo_empty) state_nxt = STREAM;
        STREAM:  if (hs && last_beat && fifo_empty) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    m_valid = (state == STREAM);
    pop     = 1'b0;
    shift   = 1'b0;
    if (!clear) begin
      case (state)
        IDLE: pop = !fifo_empty;
        STREAM: begin
          shift = hs;
          pop   = hs && last_beat && !fifo_empty;
        end
        default: ;
      endcase
    end
  end

  // A pop always reloads the shifter, taking priority over the final shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shifter <= '0;
      m_addr  <= '0;
      beat    <= '0;
    end else if (clear) begin
      shifter <= '0;
      m_addr  <= '0;
      beat    <= '0;
    end else if (pop) begin
      shifter <= head[MAP_W-1:0];
      m_addr  <= head[ENTRY_W-1 -: ADDR_WIDTH];
      beat    <= '0;
    end else if (shift) begin
      shifter <= shifter >> OUT_WIDTH;
      beat    <= last_beat ? '0 : beat + BEAT_IW'(1);
    end
  end

  assign m_data = shifter[OUT_WIDTH-1:0];
  assign m_beat = beat;
  assign m_last = (state == STREAM) && last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        overflow <= 1'b0;
    else if (clear) overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
  end

`ifdef OFM_PAIR_CHECK_EN
  logic                  pair_half;
  logic [ADDR_WIDTH-1:0] pair_first;

  // Second write must follow the first immediately with the next address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_half  <= 1'b0;
      pair_first <= '0;
      pair_err   <= 1'b0;
    end else if (clear) begin
      pair_half <= 1'b0;
      pair_err  <= 1'b0;
    end else if (pair_half) begin
      pair_half <= 1'b0;
      if (!ofm_wr || (ofm_addr != pair_first + ADDR_WIDTH'(1))) pair_err <= 1'b1;
    end else if (ofm_wr) begin
      pair_half  <= 1'b1;
      pair_first <= ofm_addr;
      if (ofm_addr[0]) pair_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ofm_drain.sv
// Self-checking bench for ofm_drain: directed table, hand sequences and random traffic
// against a map-queue reference model.
`timescale 1ns/1ps
module tb_ofm_drain;
  import ofm_drain_pkg::*;

  localparam int AW    = DEF_ADDR_WIDTH;
  localparam int OW    = DEF_OUT_WIDTH;
  localparam int DEPTH = DEF_FIFO_DEPTH;
  localparam int MB    = MAP_BITS;
  localparam int NB    = BEATS;
  localparam int BW    = BEAT_W;
  localparam int LW    = LEVEL_W;

  logic          clk = 1'b0;
  logic          rst, ofm_wr, clear, m_ready;
  logic [AW-1:0] ofm_addr;
  logic [MB-1:0] ofm_writedata;
  logic          m_valid, m_last, overflow;
  logic [OW-1:0] m_data;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_beat;
  logic [LW-1:0] level;
`ifdef OFM_PAIR_CHECK_EN
  logic          pair_err;
`endif

  always #5 clk = ~clk;

  ofm_drain dut (
    .clk           (clk),
    .rst           (rst),
    .ofm_wr        (ofm_wr),
    .ofm_addr      (ofm_addr),
    .ofm_writedata (ofm_writedata),
    .clear         (clear),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_addr        (m_addr),
    .m_beat        (m_beat),
    .m_last        (m_last),
    .level         (level),
    .overflow      (overflow)
`ifdef OFM_PAIR_CHECK_EN
    ,
    .pair_err      (pair_err)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: count of buffered maps, the map being streamed, and a queue of
  // every beat still owed to the downstream side.
  typedef struct {
    logic [AW-1:0] addr;
    logic [OW-1:0] data;
    int            idx;
  } beat_t;

  beat_t         sb[$];
  int            last_tags[$];
  int            q_cnt, left, hs_count;
  bit            act, ovf, stalled;
  logic [OW-1:0] stall_data;
  logic [AW-1:0] stall_addr;
  bit            p_half, p_err;
  logic [AW-1:0] p_first;

  task automatic model_reset();
    q_cnt = 0; left = 0; act = 0; ovf = 0; stalled = 0;
    p_half = 0; p_err = 0; p_first = '0;
    sb.delete();
  endtask

  task automatic rand_map();
    for (int w = 0; w < MB / 32; w++) ofm_writedata[w*32 +: 32] = $urandom();
  endtask

  // Compare outputs against the model, advance the model by one edge, then clock.
  task automatic tick();
    bit    hs, pop, full;
    beat_t e;
    check("m_valid", m_valid, act);
    check("level", level, q_cnt);
    check("overflow", overflow, ovf);
`ifdef OFM_PAIR_CHECK_EN
    check("pair_err", pair_err, p_err);
`endif
    if (stalled && act) begin
      check("stall_data", m_data, stall_data);
      check("stall_addr", m_addr, stall_addr);
    end
    stalled = 0;
    hs = act && m_ready;
    if (act && sb.size() > 0) begin
      e = sb[0];
      check("m_data", m_data, e.data);
      check("m_addr", m_addr, e.addr);
      check("m_beat", m_beat, e.idx);
      check("m_last", m_last, e.idx == NB - 1);
      if (hs) begin
        void'(sb.pop_front());
        hs_count++;
        if (m_last) last_tags.push_back(int'(m_addr));
      end else begin
        stalled = 1; stall_data = m_data; stall_addr = m_addr;
      end
    end
`ifdef OFM_PAIR_CHECK_EN
    if (clear) begin
      p_half = 0; p_err = 0;
    end else if (p_half) begin
      if (!ofm_wr || ofm_addr != AW'(p_first + 1)) p_err = 1;
      p_half = 0;
    end else if (ofm_wr) begin
      if (ofm_addr[0]) p_err = 1;
      p_first = ofm_addr; p_half = 1;
    end
`endif
    if (clear) begin
      q_cnt = 0; act = 0; left = 0; ovf = 0; stalled = 0;
      sb.delete();
    end else begin
      full = (q_cnt == DEPTH);
      pop  = (q_cnt > 0) && (!act || (hs && left == 1));
      if (hs) begin
        left--;
        if (left == 0) act = 0;
      end
      if (pop) begin
        q_cnt--; act = 1; left = NB;
      end
      if (ofm_wr) begin
        if (!full || pop) begin
          q_cnt++;
          for (int b = 0; b < NB; b++) begin
            e.addr = ofm_addr; e.data = ofm_writedata[b*OW +: OW]; e.idx = b;
            sb.push_back(e);
          end
        end else begin
          ovf = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_map(input logic [AW-1:0] a);
    ofm_wr = 1'b1; ofm_addr = a; rand_map();
    tick();
    ofm_wr = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    ofm_wr = 1'b0; clear = 1'b0; m_ready = 1'b1;
    while ((act || q_cnt > 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done"}, act || q_cnt > 0, 0);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic          rdy;
    logic          clr;
    logic          e_valid;
    logic [LW-1:0] e_level;
    logic          e_ovf;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, hs0;

    // Fill with m_ready low: one map in the shifter, four buffered, sixth dropped.
    tbl[0] = '{1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
    tbl[1] = '{1'b1, 7'd1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
    tbl[2] = '{1'b1, 7'd2, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0};
    tbl[3] = '{1'b1, 7'd3, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0};
    tbl[4] = '{1'b1, 7'd4, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0};
    tbl[5] = '{1'b1, 7'd5, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1};
    tbl[6] = '{1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1};

    rst = 1'b1; ofm_wr = 1'b0; ofm_addr = '0; ofm_writedata = '0;
    clear = 1'b0; m_ready = 1'b0; hs_count = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_beat", m_beat, 0);
    check("rst_m_last", m_last, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);

    foreach (tbl[i]) begin
      ofm_wr = tbl[i].wr; ofm_addr = tbl[i].addr; m_ready = tbl[i].rdy; clear = tbl[i].clr;
      rand_map();
      tick();
      check($sformatf("tbl%0d_valid", i), m_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d_level", i), level, tbl[i].e_level);
      check($sformatf("tbl%0d_ovf", i), overflow, tbl[i].e_ovf);
    end

    last_tags.delete();
    drain("ovf_drain", 400);
    check("ovf_tag_count", last_tags.size(), 5);
    for (int i = 0; i < 5 && i < last_tags.size(); i++)
      check($sformatf("ovf_tag%0d", i), last_tags[i], i);
    check("ovf_sticky", overflow, 1);

    // clear at beat 10 together with a write
    write_map(7'd30);
    m_ready = 1'b1;
    n = 0;
    while (!(m_valid && m_beat == BW'(10)) && n < 60) begin tick(); n++; end
    check("clr_reach_beat10", m_valid && m_beat == BW'(10), 1);
    clear = 1'b1; ofm_wr = 1'b1; ofm_addr = 7'd31; rand_map();
    tick();
    clear = 1'b0; ofm_wr = 1'b0;
    check("clr_m_valid", m_valid, 0);
    check("clr_m_beat", m_beat, 0);
    check("clr_level", level, 0);
    check("clr_overflow", overflow, 0);
    hs0 = hs_count;
    repeat (40) tick();
    check("clr_no_beats", hs_count - hs0, 0);

    // back-to-back pair 0/1 with m_ready high: 64 beats, no bubble
    last_tags.delete();
    write_map(7'd0);
    write_map(7'd1);
    check("pair_first_valid", m_valid, 1);
    hs0 = hs_count; n = 0;
    while (hs_count - hs0 < 2 * NB && n < 200) begin tick(); n++; end
    check("pair_cycles", n, 2 * NB);
    check("pair_tag_count", last_tags.size(), 2);
    if (last_tags.size() == 2) begin
      check("pair_tag0", last_tags[0], 0);
      check("pair_tag1", last_tags[1], 1);
    end
    drain("pair_drain", 20);

    // backpressure: m_ready toggles every cycle
    m_ready = 1'b0;
    write_map(7'd9);
    hs0 = hs_count; n = 0;
    while (hs_count - hs0 < NB && n < 200) begin
      m_ready = n[0];
      tick();
      n++;
    end
    check("bp_beats", hs_count - hs0, NB);
    drain("bp_drain", 20);

    // full FIFO with a write on the last-beat handshake
    m_ready = 1'b0;
    for (int a = 20; a < 25; a++) write_map(AW'(a));
    check("fp_full_level", level, DEPTH);
    m_ready = 1'b1; n = 0;
    while (!(m_valid && m_last) && n < 100) begin tick(); n++; end
    check("fp_reach_last", m_valid && m_last, 1);
    write_map(7'd25);
    check("fp_overflow", overflow, 0);
    check("fp_level", level, DEPTH);
    drain("fp_drain", 400);

    // asynchronous reset at beat 5
    write_map(7'd40);
    m_ready = 1'b1; n = 0;
    while (!(m_valid && m_beat == BW'(5)) && n < 60) begin tick(); n++; end
    check("rst_reach_beat5", m_valid && m_beat == BW'(5), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_m_data", m_data, 0);
    check("arst_m_beat", m_beat, 0);
    check("arst_m_addr", m_addr, 0);
    check("arst_level", level, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("post_rst_valid", m_valid, 0);
    write_map(7'd2);
    write_map(7'd4);
    check("post_rst_valid1", m_valid, 1);
    check("post_rst_beat0", m_beat, 0);
`ifdef OFM_PAIR_CHECK_EN
    check("pair_err_2_4", pair_err, 1);
`endif
    drain("rst_drain", 200);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      ofm_wr   = ($urandom_range(0, 99) < 35);
      ofm_addr = AW'($urandom());
      m_ready  = ($urandom_range(0, 99) < 60);
      clear    = ($urandom_range(0, 199) == 0);
      rand_map();
      tick();
    end
    drain("rand_drain", 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
